// File: rtl/clk_pulse_gen_if.sv
// rtl/clk_pulse_gen_if.sv - phase configuration handshake bundle for clk_pulse_gen
//
// Signals:
//   cfg_valid_i  new phase configuration offered (master -> slave)
//   cfg_ready_o  configuration can be accepted this cycle (slave -> master)
//   hi_cycles_i  high-phase length in clock cycles, 0 treated as 1
//   lo_cycles_i  low-phase length in clock cycles, 0 treated as 1
interface clk_pulse_gen_if #(
    parameter int CntW = 16
);
    logic            cfg_valid_i;
    logic            cfg_ready_o;
    logic [CntW-1:0] hi_cycles_i;
    logic [CntW-1:0] lo_cycles_i;

    modport master (
        output cfg_valid_i,
        output hi_cycles_i,
        output lo_cycles_i,
        input  cfg_ready_o
    );

    modport slave (
        input  cfg_valid_i,
        input  hi_cycles_i,
        input  lo_cycles_i,
        output cfg_ready_o
    );
endinterface

// File: rtl/clk_pulse_gen.sv
// rtl/clk_pulse_gen.sv - programmable divided clock with edge strobes and edge counter
//
// Ports:
//   clk_i       sole clock, posedge
//   rst_i       synchronous active-high reset
//   en_i        run request, level sensitive
//   cfg         phase configuration handshake (slave side)
//   cnt_clr_i   clears edge_cnt_o
//   clk_o       generated clock, registered
//   posedge_o   one-cycle strobe in the first high cycle of clk_o
//   negedge_o   one-cycle strobe in the first low cycle after a high phase
//   edge_cnt_o  saturating count of clk_o rising edges
//   busy_o      generator is not idle
module clk_pulse_gen #(
    parameter int CntW     = 16,
    parameter int EdgeCntW = 32
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                en_i,
    clk_pulse_gen_if.slave      cfg,
    input  logic                cnt_clr_i,
    output logic                clk_o,
    output logic                posedge_o,
    output logic                negedge_o,
    output logic [EdgeCntW-1:0] edge_cnt_o,
    output logic                busy_o
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HIGH = 2'd1,
        LOW  = 2'd2
    } state_t;

    localparam logic [CntW-1:0] ONE = CntW'(1);

    state_t          state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic [CntW-1:0] sh_hi_q, sh_lo_q;
    logic [CntW-1:0] new_hi, new_lo;
    logic [CntW-1:0] eff_hi;
    logic            cnt_zero;
    logic            cfg_acc;

    assign cnt_zero = (cnt_q == '0);

    // Ready only at a period boundary so a running period always completes
    // with the values it started with.
    assign cfg.cfg_ready_o = (state_q == IDLE) || ((state_q == LOW) && cnt_zero);
    assign cfg_acc         = cfg.cfg_valid_i && cfg.cfg_ready_o;

    assign new_hi = (cfg.hi_cycles_i == '0) ? ONE : cfg.hi_cycles_i;
    assign new_lo = (cfg.lo_cycles_i == '0) ? ONE : cfg.lo_cycles_i;

    // A config accepted on the same edge that starts a HIGH phase is used
    // for that phase.
    assign eff_hi = cfg_acc ? new_hi : sh_hi_q;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (en_i) begin
                    state_d = HIGH;
                    cnt_d   = eff_hi - ONE;
                end
            end
            HIGH: begin
                // No config can be accepted in HIGH, so the shadow low value
                // is the one that belongs to this period.
                if (cnt_zero) begin
                    state_d = LOW;
                    cnt_d   = sh_lo_q - ONE;
                end else begin
                    cnt_d = cnt_q - ONE;
                end
            end
            LOW: begin
                if (cnt_zero) begin
                    if (en_i) begin
                        state_d = HIGH;
                        cnt_d   = eff_hi - ONE;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    cnt_d = cnt_q - ONE;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            sh_hi_q   <= ONE;
            sh_lo_q   <= ONE;
            clk_o     <= 1'b0;
            posedge_o <= 1'b0;
            negedge_o <= 1'b0;
            busy_o    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            if (cfg_acc) begin
                sh_hi_q <= new_hi;
                sh_lo_q <= new_lo;
            end
            clk_o     <= (state_d == HIGH);
            posedge_o <= (state_d == HIGH) && (state_q != HIGH);
            negedge_o <= (state_q == HIGH) && (state_d != HIGH);
            busy_o    <= (state_d != IDLE);
        end
    end

    // The count advances at the end of each posedge_o cycle; a clear in that
    // same cycle keeps the edge being counted.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            edge_cnt_o <= '0;
        end else if (cnt_clr_i) begin
            edge_cnt_o <= {{(EdgeCntW-1){1'b0}}, posedge_o};
        end else if (posedge_o && (edge_cnt_o != '1)) begin
            edge_cnt_o <= edge_cnt_o + EdgeCntW'(1);
        end
    end

endmodule

// File: tb/tb_clk_pulse_gen.sv
// tb/tb_clk_pulse_gen.sv - self-checking bench for clk_pulse_gen
module tb_clk_pulse_gen;

    localparam int CW      = 16;
    localparam int ECW     = 4;
    localparam int CNT_MAX = (1 << ECW) - 1;

    logic           clk = 1'b0;
    logic           rst_i = 1'b1;
    logic           en_i = 1'b0;
    logic           cnt_clr_i = 1'b0;
    logic           clk_o, posedge_o, negedge_o, busy_o;
    logic [ECW-1:0] edge_cnt_o;

    clk_pulse_gen_if #(.CntW(CW)) cfg_if ();

    clk_pulse_gen #(
        .CntW     (CW),
        .EdgeCntW (ECW)
    ) u_dut (
        .clk_i      (clk),
        .rst_i      (rst_i),
        .en_i       (en_i),
        .cfg        (cfg_if.slave),
        .cnt_clr_i  (cnt_clr_i),
        .clk_o      (clk_o),
        .posedge_o  (posedge_o),
        .negedge_o  (negedge_o),
        .edge_cnt_o (edge_cnt_o),
        .busy_o     (busy_o)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_mis = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_mis++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Reference model: position inside the current period plus the period's
    // hi/lo lengths; clk is high while the position is below hi.
    bit m_init = 0;
    bit m_run  = 0;
    int m_pos  = 0;
    int m_hi   = 1;
    int m_lo   = 1;
    int sh_hi  = 1;
    int sh_lo  = 1;
    int m_cnt  = 0;
    bit e_clk  = 0;
    bit e_pe   = 0;
    bit e_ne   = 0;

    task automatic step(input bit r, input bit e, input bit v,
                        input int h, input int l, input bit c);
        bit ready;
        bit new_clk;
        rst_i                = r;
        en_i                 = e;
        cfg_if.cfg_valid_i   = v;
        cfg_if.hi_cycles_i   = CW'(h);
        cfg_if.lo_cycles_i   = CW'(l);
        cnt_clr_i            = c;
        ready = !m_run || (m_pos == m_hi + m_lo - 1);
        if (m_init) check("cfg_ready", cfg_if.cfg_ready_o, ready);
        if (r) begin
            m_run = 0; m_pos = 0; sh_hi = 1; sh_lo = 1; m_cnt = 0;
            e_clk = 0; e_pe = 0; e_ne = 0; m_init = 1;
        end else begin
            if (v && ready) begin
                sh_hi = (h == 0) ? 1 : h;
                sh_lo = (l == 0) ? 1 : l;
            end
            if (c) m_cnt = e_pe ? 1 : 0;
            else if (e_pe && m_cnt < CNT_MAX) m_cnt++;
            if (!m_run) begin
                if (e) begin
                    m_run = 1; m_pos = 0; m_hi = sh_hi; m_lo = sh_lo;
                end
            end else if (m_pos == m_hi + m_lo - 1) begin
                if (e) begin
                    m_pos = 0; m_hi = sh_hi; m_lo = sh_lo;
                end else begin
                    m_run = 0;
                end
            end else begin
                m_pos++;
            end
            new_clk = m_run && (m_pos < m_hi);
            e_pe  = new_clk && !e_clk;
            e_ne  = !new_clk && e_clk;
            e_clk = new_clk;
        end
        @(posedge clk);
        #1;
        if (m_init) begin
            check("clk_o",      clk_o,      e_clk);
            check("posedge_o",  posedge_o,  e_pe);
            check("negedge_o",  negedge_o,  e_ne);
            check("busy_o",     busy_o,     m_run);
            check("edge_cnt_o", edge_cnt_o, m_cnt);
        end
    endtask

    task automatic idle_out();
        for (int i = 0; i < 30; i++) step(0, 0, 0, 0, 0, 0);
        check("stop_busy", busy_o, 0);
    endtask

    logic [9:0] pat;
    bit         en_r;
    bit         seen;

    initial begin
        cfg_if.cfg_valid_i = 1'b0;
        cfg_if.hi_cycles_i = '0;
        cfg_if.lo_cycles_i = '0;
        #2;
        step(1, 0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0);
        check("rst_clk",  clk_o, 0);
        check("rst_busy", busy_o, 0);
        check("rst_cnt",  edge_cnt_o, 0);
        check("rst_ready", cfg_if.cfg_ready_o, 1);

        // Basic period hi=2 lo=3
        step(0, 0, 1, 2, 3, 0);
        pat = '0;
        for (int i = 0; i < 10; i++) begin
            step(0, 1, 0, 0, 0, 0);
            pat = {pat[8:0], clk_o};
        end
        check("t1_pattern", pat, 10'b1100011000);
        for (int i = 0; i < 10; i++) step(0, 1, 0, 0, 0, 0);
        check("t1_cnt", edge_cnt_o, 4);
        idle_out();

        // Zero fields: period 2
        step(0, 0, 1, 0, 0, 0);
        pat = '0;
        for (int i = 0; i < 10; i++) begin
            step(0, 1, 0, 0, 0, 0);
            pat = {pat[8:0], clk_o};
            check("t2_not_both", posedge_o & negedge_o, 0);
        end
        check("t2_pattern", pat, 10'b1010101010);
        idle_out();

        // Mid-run reconfig 4/4 -> 1/1 with valid held
        step(0, 0, 1, 4, 4, 0);
        for (int i = 0; i < 3; i++) step(0, 1, 0, 0, 0, 0);
        for (int i = 0; i < 8; i++) step(0, 1, 1, 1, 1, 0);
        for (int i = 0; i < 6; i++) step(0, 1, 0, 0, 0, 0);
        idle_out();

        // Graceful stop 3/3, en dropped in 2nd HIGH cycle
        step(0, 0, 1, 3, 3, 0);
        step(0, 1, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0);
        check("t4_still_high", clk_o, 1);
        idle_out();

        // Reset during HIGH, then defaults 1/1 -> 20 edges saturate at 15
        step(0, 0, 1, 5, 2, 0);
        step(0, 1, 0, 0, 0, 0);
        step(0, 1, 0, 0, 0, 0);
        step(1, 1, 0, 0, 0, 0);
        check("t5_clk",  clk_o, 0);
        check("t5_neg",  negedge_o, 0);
        check("t5_cnt",  edge_cnt_o, 0);
        for (int i = 0; i < 40; i++) step(0, 1, 0, 0, 0, 0);
        check("t6_sat", edge_cnt_o, CNT_MAX);

        // Clear coincident with posedge_o
        seen = 0;
        for (int i = 0; i < 10 && !seen; i++) begin
            if (posedge_o) seen = 1;
            else step(0, 1, 0, 0, 0, 0);
        end
        check("t6_pe_seen", seen, 1);
        step(0, 1, 0, 0, 0, 0 | 1'b1);
        check("t6_clr_pe", edge_cnt_o, 1);

        // Randomized run
        en_r = 1;
        for (int i = 0; i < 4000; i++) begin
            bit r, v, c;
            int h, l;
            if ($urandom_range(0, 19) == 0) en_r = ~en_r;
            r = ($urandom_range(0, 199) == 0);
            v = ($urandom_range(0, 5) == 0);
            c = ($urandom_range(0, 24) == 0);
            h = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 12)) : int'($urandom_range(0, 4));
            l = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 12)) : int'($urandom_range(0, 4));
            step(r, en_r, v, h, l, c);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule

// File: doc/clk_pulse_gen.md
Name: clk_pulse_gen

Overview:
- Synthesizable programmable clock/edge generator. It is the driving end of the clock-event abstraction that DV utilities consume.
- Produces a registered divided clock `clk_o` with independently programmable high and low phase lengths, measured in `clk_i` cycles.
- Also produces one-cycle rising/falling edge strobes and a saturating rising-edge counter.
- Used in testbench harnesses and DV-support RTL wherever a slow derived clock or tick source must be driven into a clock interface.

Parameters:
- CntW, 16, width of the high/low phase-length configuration fields.
- EdgeCntW, 32, width of the rising-edge counter.

Ports:
- clk_i  input  1  sole clock; all logic is on the posedge.
- rst_i  input  1  synchronous, active-high reset.
- en_i  input  1  run request; level-sensitive.
- cfg_valid_i  input  1  new phase configuration offered.
- cfg_ready_o  output  1  configuration can be accepted this cycle.
- hi_cycles_i  input  CntW  high-phase length in clk_i cycles; 0 is treated as 1.
- lo_cycles_i  input  CntW  low-phase length in clk_i cycles; 0 is treated as 1.
- cnt_clr_i  input  1  clears edge_cnt_o.
- clk_o  output  1  generated clock, registered, glitch-free.
- posedge_o  output  1  high in the first clk_i cycle that clk_o is 1.
- negedge_o  output  1  high in the first clk_i cycle that clk_o is 0 after a high phase.
- edge_cnt_o  output  EdgeCntW  number of clk_o rising edges; saturates.
- busy_o  output  1  state is not IDLE.

Behaviour:
- **Reset:** synchronous, active-high.
  - State = IDLE.
  - clk_o, posedge_o, negedge_o, busy_o = 0.
  - edge_cnt_o = 0.
  - Shadow config hi = 1, lo = 1.
  - Phase counter = 0.
  - rst_i asserted mid-period aborts immediately: clk_o = 0 on the next edge, with no negedge_o strobe.
- **Zero-length fields:** hi_cycles_i / lo_cycles_i of 0 are stored as 1, so the minimum period is 2 clk_i cycles (clk_i/2).
- **Config handshake:**
  - Transfer occurs on cfg_valid_i && cfg_ready_o; shadow hi/lo are loaded on that edge.
  - cfg_ready_o = (state == IDLE) || (state == LOW && last low cycle). It is combinational from state and counter, never from cfg_valid_i.
  - A new config therefore takes effect only at a period boundary; the current period always completes with the old values.
- **FSM states:** IDLE, HIGH, LOW.
  - **IDLE:** clk_o = 0. If en_i = 1, go to HIGH next cycle, load counter = shadow hi − 1.
    - If a config is accepted in the same cycle, the HIGH phase uses the new value.
  - **HIGH:** clk_o = 1. The counter decrements each cycle; at 0, go to LOW and load counter = lo − 1.
    - en_i deassertion is ignored in HIGH; the phase always completes.
  - **LOW:** clk_o = 0. The counter decrements each cycle; at 0:
    - en_i = 1: go to HIGH, load counter = hi − 1, using any config accepted this cycle.
    - en_i = 0: go to IDLE.
    - en_i drop together with a config accept: the config is stored and the FSM goes to IDLE.
- **clk_o timing:**
  - clk_o is the registered (state == HIGH).
  - The first rising edge appears 1 cycle after en_i is sampled high in IDLE.
  - Period = hi + lo cycles; high time = hi, low time = lo.
  - Disabling never truncates a phase: clk_o ends low after a full LOW phase.
- **Edge strobes:**
  - posedge_o = 1 exactly in the cycles where clk_o goes 0→1.
  - negedge_o = 1 exactly in the cycles where clk_o goes 1→0.
  - Both are registered, aligned with clk_o, and never high together.
- **edge_cnt_o:**
  - Increments on every posedge_o cycle and saturates at all-ones (no wrap).
  - cnt_clr_i alone → 0.
  - cnt_clr_i in the same cycle as a rising edge → 1.
- **busy_o:** equals (state != IDLE), registered alongside clk_o.

Test Plan:
1. **Basic period:** reset, cfg hi=2 lo=3 accepted in IDLE, en_i=1 → clk_o pattern 1,1,0,0,0 repeating with period 5; posedge_o every 5 cycles; edge_cnt_o = 4 after 20 cycles of running.
2. **Zero fields:** cfg hi=0 lo=0 → clk_o toggles every cycle (period 2); posedge_o and negedge_o alternate and are never coincident.
3. **Mid-run reconfig:** running hi=4 lo=4; offer hi=1 lo=1 with cfg_valid_i held → cfg_ready_o high only on the last LOW cycle; the current 8-cycle period completes, then the period becomes 2.
4. **Graceful stop:** running hi=3 lo=3; drop en_i in the 2nd HIGH cycle → HIGH finishes, 3 LOW cycles, then IDLE; busy_o = 0; no further posedge_o.
5. **Reset mid-operation:** assert rst_i in a HIGH cycle → next edge: clk_o = 0, edge_cnt_o = 0, no negedge_o; shadow config returns to 1/1 (period 2 on re-enable).
6. **Counter corners:**
   - With EdgeCntW=4 and 20 rising edges → edge_cnt_o sticks at 15.
   - cnt_clr_i coincident with posedge_o → edge_cnt_o = 1.
